// File: rtl/cei_mochila_pkg.sv
// Wrapper-level constants for the CSR access path.
package cei_mochila_pkg;

  localparam int unsigned WRAPPER_CSR_TIMEOUT = 255;
  localparam logic [31:0] WRAPPER_CSR_ERR_RDATA = 32'hBADC_AB1E;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the core data ports.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-interface request/response bundles.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/csr_rr_arbiter.sv
// Combinational round-robin pick; search starts at ptr and wraps.
module csr_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        k = W'((int'(ptr) + i) % N);
        if (!found && req[k]) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          idx    = k;
        end
      end
    end
  end

endmodule

// File: rtl/obi_reg_csr_bridge.sv
// N-master OBI plus external reg port onto one CSR reg port,
// round-robin arbitrated, one transaction in flight, with timeout.
module obi_reg_csr_bridge
  import obi_pkg::*;
  import reg_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int          NMASTER        = 3,
  parameter int unsigned TIMEOUT_CYCLES = WRAPPER_CSR_TIMEOUT,
  parameter logic [31:0] ERR_RDATA      = WRAPPER_CSR_ERR_RDATA
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  obi_req_t                       obi_req_i  [NMASTER],
  output obi_resp_t                      obi_resp_o [NMASTER],
  input  reg_req_t                       ext_reg_req_i,
  output reg_rsp_t                       ext_reg_rsp_o,
  output reg_req_t                       reg_req_o,
  input  reg_rsp_t                       reg_rsp_i,
  output logic                           err_o,
  output logic [$clog2(NMASTER+1)-1:0]   err_src_o
);

  localparam int NSRC = NMASTER + 1;
  localparam int SW = $clog2(NSRC);
  localparam logic [SW-1:0] EXT = SW'(NMASTER);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] err_src_q;
  logic [7:0]    cnt_q, cnt_d;
  reg_req_t      lat_q, lat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [NSRC-1:0] arb_req, arb_gnt;
  logic [SW-1:0] arb_idx;
  logic          arb_en;
  logic          own_ext;
  logic          timeout_hit;

  // Grants are held off while reset is asserted so outputs stay 0.
  assign arb_en = (state_q == IDLE) && !rst_i;
  assign own_ext = (owner_q == EXT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  assign err_src_o = err_o ? owner_q : err_src_q;

  always_comb begin
    arb_req = '0;
    for (int i = 0; i < NMASTER; i++) begin
      arb_req[i] = obi_req_i[i].req;
    end
    arb_req[NMASTER] = ext_reg_req_i.valid;
  end

  csr_rr_arbiter #(
    .N (NSRC),
    .W (SW)
  ) u_arb (
    .req (arb_req),
    .ptr (rr_q),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    for (int i = 0; i < NMASTER; i++) begin
      obi_resp_o[i] = '0;
    end
    reg_req_o     = '0;
    ext_reg_rsp_o = '0;
    err_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          owner_d = arb_idx;
          rr_d    = (arb_idx == EXT) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
          for (int i = 0; i < NMASTER; i++) begin
            if (arb_gnt[i]) begin
              obi_resp_o[i].gnt = 1'b1;
              lat_d.addr  = obi_req_i[i].addr;
              lat_d.write = obi_req_i[i].we;
              lat_d.wdata = obi_req_i[i].wdata;
              lat_d.wstrb = obi_req_i[i].be;
              lat_d.valid = 1'b0;
            end
          end
        end
      end
      ACCESS: begin
        reg_req_o       = own_ext ? ext_reg_req_i : lat_q;
        reg_req_o.valid = 1'b1;
        // A ready in the expiry cycle takes priority over the abort.
        if (reg_rsp_i.ready) begin
          err_o = reg_rsp_i.error;
          if (own_ext) begin
            ext_reg_rsp_o = reg_rsp_i;
            state_d       = IDLE;
          end else begin
            rdata_d = reg_rsp_i.rdata;
            state_d = RESP;
          end
        end else if (timeout_hit) begin
          err_o = 1'b1;
          if (own_ext) begin
            ext_reg_rsp_o.ready = 1'b1;
            ext_reg_rsp_o.error = 1'b1;
            state_d             = IDLE;
          end else begin
            rdata_d = ERR_RDATA;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        for (int i = 0; i < NMASTER; i++) begin
          if (owner_q == SW'(i)) begin
            obi_resp_o[i].rvalid = 1'b1;
            obi_resp_o[i].rdata  = rdata_q;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      err_src_q <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      err_src_q <= err_src_o;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
